// File: rtl/hd44780_lcd_ctrl.sv
// rtl/hd44780_lcd_ctrl.sv - HD44780 16x2 character LCD write controller
// Purpose: after reset, runs the HD44780 power-on init table on its own. It then
//   writes one host command/data byte per valid/ready handshake over the 8-bit bus.
//   Each write has three phases (setup, E-high, hold), followed by a post-write delay.
// Option: define HD44780_BUSY_POLL_EN to replace the fixed post-write delay of host
//   bytes with busy-flag read cycles. These repeat until DB7=0 or a 2 ms timeout.
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   host_valid/rs/data       upstream byte; host_rs 0=command, 1=data
//   host_ready               idle and accepting (only after init_done)
//   lcd_rs/rw/e              LCD control pins
//   lcd_data_o/i, lcd_data_oe  DB7..DB0 drive value, sampled value, drive enable
//   init_done                init sequence finished, sticky until rst
module hd44780_lcd_ctrl #(
  parameter int CLOCK_HZ   = 50_000_000,
  parameter int POWERUP_US = 50_000,
  parameter int EPHASE_NS  = 1_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_valid,
  input  logic       host_rs,
  input  logic [7:0] host_data,
  output logic       host_ready,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data_o,
  input  logic [7:0] lcd_data_i,
  output logic       lcd_data_oe,
  output logic       init_done
);

  // ceil(ns * CLOCK_HZ / 1e9), never below one cycle
  function automatic longint ns_to_cyc(input longint ns);
    longint c;
    c = (ns * longint'(CLOCK_HZ) + longint'(999_999_999)) / longint'(1_000_000_000);
    return (c < 1) ? longint'(1) : c;
  endfunction

  function automatic longint max2(input longint a, input longint b);
    return (a > b) ? a : b;
  endfunction

  localparam longint C_PWR  = ns_to_cyc(longint'(POWERUP_US) * 1000);
  localparam longint C_E    = ns_to_cyc(longint'(EPHASE_NS));
  localparam longint C_4M1  = ns_to_cyc(4_100_000);
  localparam longint C_2M   = ns_to_cyc(2_000_000);
  localparam longint C_100U = ns_to_cyc(100_000);
  localparam longint C_50U  = ns_to_cyc(50_000);
  localparam longint C_MAX  = max2(max2(C_PWR, C_E), max2(C_4M1, C_2M));
  localparam int     CW     = $clog2(C_MAX) + 1;

  // Counters load (cycles - 1) and leave their state when they reach zero
  localparam logic [CW-1:0] L_PWR  = CW'(C_PWR - 1);
  localparam logic [CW-1:0] L_E    = CW'(C_E - 1);
  localparam logic [CW-1:0] L_4M1  = CW'(C_4M1 - 1);
  localparam logic [CW-1:0] L_2M   = CW'(C_2M - 1);
  localparam logic [CW-1:0] L_100U = CW'(C_100U - 1);
  localparam logic [CW-1:0] L_50U  = CW'(C_50U - 1);

  typedef enum logic [3:0] {
    ST_POWERUP, ST_INIT_LOAD, ST_SETUP, ST_E_HIGH, ST_HOLD, ST_WAIT, ST_IDLE,
    ST_BF_SETUP, ST_BF_E_HIGH, ST_BF_HOLD
  } state_t;

  function automatic logic [7:0] init_byte(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: return 8'h30;
      3'd3:             return 8'h38;
      3'd4:             return 8'h08;
      3'd5:             return 8'h01;
      3'd6:             return 8'h06;
      default:          return 8'h0C;
    endcase
  endfunction

  function automatic logic [CW-1:0] init_wait(input logic [2:0] i);
    case (i)
      3'd0:       return L_4M1;
      3'd1, 3'd2: return L_100U;
      3'd5:       return L_2M;
      default:    return L_50U;
    endcase
  endfunction

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] wait_ld;
  logic [2:0]    idx;

`ifdef HD44780_BUSY_POLL_EN
  logic          rw_q;
  logic          oe_q;
  logic          busy;
  logic [CW-1:0] tmo;
  logic          unused_lcd_data_lo;
  assign lcd_rw             = rw_q;
  assign lcd_data_oe        = oe_q;
  assign unused_lcd_data_lo = ^lcd_data_i[6:0];
`else
  logic          unused_lcd_data_i;
  assign lcd_rw            = 1'b0;
  assign lcd_data_oe       = 1'b1;
  assign unused_lcd_data_i = ^lcd_data_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_POWERUP;
      cnt        <= L_PWR;
      wait_ld    <= L_50U;
      idx        <= 3'd0;
      host_ready <= 1'b0;
      init_done  <= 1'b0;
      lcd_e      <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data_o <= 8'h00;
`ifdef HD44780_BUSY_POLL_EN
      rw_q       <= 1'b0;
      oe_q       <= 1'b1;
      busy       <= 1'b0;
      tmo        <= '0;
`endif
    end else begin
`ifdef HD44780_BUSY_POLL_EN
      // Free-running timeout; reloaded when a poll sequence starts
      if (tmo != '0) tmo <= tmo - 1'b1;
`endif
      case (state)
        ST_POWERUP: begin
          if (cnt == '0) state <= ST_INIT_LOAD;
          else           cnt   <= cnt - 1'b1;
        end
        ST_INIT_LOAD: begin
          lcd_rs     <= 1'b0;
          lcd_data_o <= init_byte(idx);
          wait_ld    <= init_wait(idx);
          cnt        <= L_E;
          state      <= ST_SETUP;
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            lcd_e <= 1'b1;
            cnt   <= L_E;
            state <= ST_E_HIGH;
          end else cnt <= cnt - 1'b1;
        end
        ST_E_HIGH: begin
          if (cnt == '0) begin
            lcd_e <= 1'b0;
            cnt   <= L_E;
            state <= ST_HOLD;
          end else cnt <= cnt - 1'b1;
        end
        ST_HOLD: begin
          if (cnt == '0) begin
`ifdef HD44780_BUSY_POLL_EN
            if (init_done) begin
              lcd_rs <= 1'b0;
              rw_q   <= 1'b1;
              oe_q   <= 1'b0;
              tmo    <= L_2M;
              cnt    <= L_E;
              state  <= ST_BF_SETUP;
            end else
`endif
            begin
              cnt   <= wait_ld;
              state <= ST_WAIT;
            end
          end else cnt <= cnt - 1'b1;
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            // init_done=0 means the init table is still running
            if (!init_done && idx != 3'd7) begin
              idx   <= idx + 3'd1;
              state <= ST_INIT_LOAD;
            end else begin
              init_done  <= 1'b1;
              host_ready <= 1'b1;
              state      <= ST_IDLE;
            end
          end else cnt <= cnt - 1'b1;
        end
        ST_IDLE: begin
          if (host_valid && host_ready) begin
            host_ready <= 1'b0;
            lcd_rs     <= host_rs;
            lcd_data_o <= host_data;
            // Clear display and return home need the long delay
            wait_ld    <= (!host_rs && (host_data == 8'h01 || host_data == 8'h02)) ? L_2M : L_50U;
            cnt        <= L_E;
            state      <= ST_SETUP;
          end
        end
`ifdef HD44780_BUSY_POLL_EN
        ST_BF_SETUP: begin
          if (cnt == '0) begin
            lcd_e <= 1'b1;
            cnt   <= L_E;
            state <= ST_BF_E_HIGH;
          end else cnt <= cnt - 1'b1;
        end
        ST_BF_E_HIGH: begin
          if (cnt == '0) begin
            busy  <= lcd_data_i[7];
            lcd_e <= 1'b0;
            cnt   <= L_E;
            state <= ST_BF_HOLD;
          end else cnt <= cnt - 1'b1;
        end
        ST_BF_HOLD: begin
          if (cnt == '0) begin
            if (busy && tmo != '0) begin
              cnt   <= L_E;
              state <= ST_BF_SETUP;
            end else begin
              rw_q       <= 1'b0;
              oe_q       <= 1'b1;
              host_ready <= 1'b1;
              state      <= ST_IDLE;
            end
          end else cnt <= cnt - 1'b1;
        end
`endif
        default: state <= ST_POWERUP;
      endcase
    end
  end

endmodule

// File: tb/tb_hd44780_lcd_ctrl.sv
// tb/tb_hd44780_lcd_ctrl.sv - scoreboard bench for hd44780_lcd_ctrl
module tb_hd44780_lcd_ctrl;

  localparam int CLOCK_HZ   = 2_500_000;
  localparam int POWERUP_US = 100;
  localparam int EPHASE_NS  = 1000;
  // Cycle counts at 2.5 MHz, rounded up: 1 us -> 2.5 -> 3; 50 us -> 125; 100 us -> 250;
  // 2 ms -> 5000; 4.1 ms -> 10250; power-up 100 us -> 250
  localparam int EC = 3, PC = 250, W50 = 125, W100 = 250, W2M = 5000, W4M1 = 10250;
  localparam int LIMIT = 30000;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         wcyc;
    bit         init;
    bit         last;
  } item_t;

  item_t exp_q[$];
  int    tests = 0;
  int    fails = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_valid = 1'b0;
  logic       host_rs = 1'b0;
  logic [7:0] host_data = 8'h00;
  logic [7:0] lcd_data_i = 8'h00;
  logic       host_ready, lcd_rs, lcd_rw, lcd_e, lcd_data_oe, init_done;
  logic [7:0] lcd_data_o;

  int init_data [8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
  int init_wcyc [8] = '{W4M1, W100, W100, W50, W50, W2M, W50, W50};

  always #5 clk = ~clk;

  hd44780_lcd_ctrl #(
    .CLOCK_HZ  (CLOCK_HZ),
    .POWERUP_US(POWERUP_US),
    .EPHASE_NS (EPHASE_NS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .host_valid (host_valid),
    .host_rs    (host_rs),
    .host_data  (host_data),
    .host_ready (host_ready),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_e      (lcd_e),
    .lcd_data_o (lcd_data_o),
    .lcd_data_i (lcd_data_i),
    .lcd_data_oe(lcd_data_oe),
    .init_done  (init_done)
  );

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic int host_wait(input logic r, input logic [7:0] d);
    return (r == 1'b0 && (d == 8'h01 || d == 8'h02)) ? W2M : W50;
  endfunction

  task automatic push_init();
    item_t it;
    for (int i = 0; i < 8; i++) begin
      it.rs   = 1'b0;
      it.data = 8'(init_data[i]);
      it.wcyc = init_wcyc[i];
      it.init = 1'b1;
      it.last = (i == 7);
      exp_q.push_back(it);
    end
  endtask

  // Presents a byte and waits for acceptance. junk=1 first drives a different byte
  // while the controller is still busy; it must be ignored.
  task automatic send(input logic r, input logic [7:0] d, input bit keep, input bit junk);
    item_t it;
    int t;
    if (junk) begin
      host_valid = 1'b1;
      host_rs    = ~r;
      host_data  = ~d;
      repeat (3) begin @(posedge clk); #1; end
    end
    it.rs   = r;
    it.data = d;
    it.wcyc = host_wait(r, d);
    it.init = 1'b0;
    it.last = 1'b0;
    exp_q.push_back(it);
    host_rs    = r;
    host_data  = d;
    host_valid = 1'b1;
    t = 0;
    while (!host_ready && t < LIMIT) begin @(posedge clk); #1; t++; end
    if (!host_ready) begin
      check("accept_timeout", 1'b0, t, LIMIT);
      host_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      check("ready_drop", host_ready == 1'b0, host_ready, 0);
      if (!keep) host_valid = 1'b0;
    end
  endtask

  // Monitor: pops one expected byte per E pulse and checks phase timing
  int    cyc = 0, rise_c = 0, fall_c = 0, chg_c = 0, rel_c = 0, hold_at = -1;
  int    gap_exp = 0, rdy_exp = 0;
  bit    first_pend = 1'b1, gap_pend = 1'b0, rdy_pend = 1'b0;
  item_t cur;
  logic  prev_e = 1'b0, prev_rdy = 1'b0;
  logic [8:0] prev_bus = 9'h000;

  initial begin
    cur.rs = 1'b0; cur.data = 8'h00; cur.wcyc = 0; cur.init = 1'b0; cur.last = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        gap_pend   = 1'b0;
        rdy_pend   = 1'b0;
        hold_at    = -1;
        first_pend = 1'b1;
        rel_c      = cyc;
      end else begin
        if ({lcd_rs, lcd_data_o} != prev_bus) chg_c = cyc;
        if (lcd_e && !prev_e) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", 1'b0, {lcd_rs, lcd_data_o}, -1);
          end else begin
            cur = exp_q.pop_front();
            check("pulse_byte", {lcd_rs, lcd_data_o} == {cur.rs, cur.data},
                  {lcd_rs, lcd_data_o}, {cur.rs, cur.data});
            check("setup_time", (cyc - chg_c) >= EC, cyc - chg_c, EC);
            check("init_done_at_pulse", init_done == !cur.init, init_done, !cur.init);
            check("write_mode", {lcd_rw, lcd_data_oe} == 2'b01, {lcd_rw, lcd_data_oe}, 1);
            if (first_pend) check("powerup_delay", (cyc - rel_c) >= PC + EC, cyc - rel_c, PC + EC);
            if (gap_pend) check("init_gap", (cyc - fall_c) == gap_exp, cyc - fall_c, gap_exp);
          end
          first_pend = 1'b0;
          gap_pend   = 1'b0;
          rise_c     = cyc;
        end
        if (!lcd_e && prev_e) begin
          check("e_width", (cyc - rise_c) == EC, cyc - rise_c, EC);
          fall_c  = cyc;
          hold_at = cyc + EC;
          if (cur.init && !cur.last) begin
            gap_pend = 1'b1;
            gap_exp  = 2 * EC + cur.wcyc + 1;
          end else begin
            rdy_pend = 1'b1;
            rdy_exp  = EC + cur.wcyc;
          end
        end
        if (cyc == hold_at) check("bus_stable", chg_c <= rise_c - EC, chg_c, rise_c - EC);
        if (host_ready && !prev_rdy) begin
          if (!rdy_pend) check("unexpected_ready", 1'b0, cyc, -1);
          else           check("post_write_wait", (cyc - fall_c) == rdy_exp, cyc - fall_c, rdy_exp);
          check("ready_with_init_done", init_done == 1'b1, init_done, 1);
          rdy_pend = 1'b0;
        end
      end
      prev_e   = lcd_e;
      prev_rdy = host_ready;
      prev_bus = {lcd_rs, lcd_data_o};
    end
  end

  initial begin
    logic       r;
    logic [7:0] d;
    int         sel, gap, t;
    bit         keep;

    repeat (5) begin @(posedge clk); #1; end
    check("rst_lcd_e", lcd_e == 1'b0, lcd_e, 0);
    check("rst_lcd_rs", lcd_rs == 1'b0, lcd_rs, 0);
    check("rst_lcd_rw", lcd_rw == 1'b0, lcd_rw, 0);
    check("rst_lcd_data", lcd_data_o == 8'h00, lcd_data_o, 0);
    check("rst_lcd_oe", lcd_data_oe == 1'b1, lcd_data_oe, 1);
    check("rst_host_ready", host_ready == 1'b0, host_ready, 0);
    check("rst_init_done", init_done == 1'b0, init_done, 0);

    push_init();
    rst = 1'b0;

    send(1'b1, 8'h55, 1'b0, 1'b0);   // valid held throughout init
    send(1'b1, 8'h41, 1'b0, 1'b0);
    send(1'b0, 8'h01, 1'b0, 1'b0);
    send(1'b0, 8'h0C, 1'b0, 1'b0);

    keep = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sel = int'($urandom_range(0, 9));
      r   = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      if (sel == 0) begin
        r = 1'b0;
        d = 8'($urandom_range(1, 2));
      end
      gap  = int'($urandom_range(0, 3));
      keep = (gap == 0);
      send(r, d, keep, sel == 9);
      repeat (gap) begin @(posedge clk); #1; end
    end

    // Reset in the middle of a host write's E-high phase
    d = 8'($urandom);
    send(1'b1, d, 1'b0, 1'b0);
    t = 0;
    while (!lcd_e && t < LIMIT) begin @(posedge clk); #1; t++; end
    check("e_rise_seen", lcd_e == 1'b1, t, LIMIT);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("abort_lcd_e", lcd_e == 1'b0, lcd_e, 0);
    check("abort_init_done", init_done == 1'b0, init_done, 0);
    check("abort_host_ready", host_ready == 1'b0, host_ready, 0);
    @(posedge clk); #1;
    push_init();
    rst = 1'b0;
    t = 0;
    while (!init_done && t < LIMIT) begin @(posedge clk); #1; t++; end
    check("reinit_done", init_done == 1'b1, t, LIMIT);
    repeat (10) begin @(posedge clk); #1; end
    check("queue_empty", exp_q.size() == 0, exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
